// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with scoreboard busy bits
//
// Holds NREGS registers of XLEN bits with two combinational read ports, one
// writeback port and a per-register busy (pending-write) vector. After reset
// an INIT sweep writes 0 to every register, one per cycle, before the file
// reports ready and starts accepting traffic.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   reset_n             asynchronous active-low reset
//   ready               1 once the init sweep is complete (registered)
//   rs1_sel/rs2_sel     read addresses
//   rs1_out/rs2_out     read data (combinational, writeback bypassed)
//   rs1_busy/rs2_busy   pending-write flag of the addressed register
//   rd_we/rd_sel/rd_data  writeback: data write plus busy clear
//   iss_valid/iss_sel   issue: marks iss_sel busy from the next cycle
//   flush               clears every busy bit
//
// Handshake: there is no per-transfer valid/ready pair. ready is a level
// status; while it is high, rd_we, iss_valid and flush are acted on in every
// cycle they are asserted, and while it is low they are ignored.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       ready,
  input  logic [$clog2(NREGS)-1:0]   rs1_sel,
  output logic [XLEN-1:0]            rs1_out,
  output logic                       rs1_busy,
  input  logic [$clog2(NREGS)-1:0]   rs2_sel,
  output logic [XLEN-1:0]            rs2_out,
  output logic                       rs2_busy,
  input  logic                       rd_we,
  input  logic [$clog2(NREGS)-1:0]   rd_sel,
  input  logic [XLEN-1:0]            rd_data,
  input  logic                       iss_valid,
  input  logic [$clog2(NREGS)-1:0]   iss_sel,
  input  logic                       flush
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  ready_q;
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [XLEN-1:0]       regs_q [NREGS];

  logic                  run;
  logic                  wr_en;
  logic                  hit1;
  logic                  hit2;

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Address 0 is hard-wired to zero, so a writeback to it is dropped.
  assign wr_en = run && rd_we && (rd_sel != '0);

  // Bypass hits only on a live, non-zero writeback to the same address.
  assign hit1 = wr_en && (rs1_sel == rd_sel);
  assign hit2 = wr_en && (rs2_sel == rd_sel);

  // Busy update priority: writeback clear first, then flush clears all,
  // otherwise an issue sets. A same-address issue therefore beats the clear.
  always_comb begin
    busy_d = busy_q;
    if (rd_we) begin
      busy_d[rd_sel] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_valid && (iss_sel != '0)) begin
      busy_d[iss_sel] = 1'b1;
    end
  end

  // Control FSM: sweep counter, ready flag and busy vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset: the INIT sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[rd_sel] <= rd_data;
    end
  end

  // Read port 1
  always_comb begin
    rs1_out  = '0;
    rs1_busy = 1'b0;
    if (run && (rs1_sel != '0)) begin
      rs1_out  = hit1 ? rd_data : regs_q[rs1_sel];
      rs1_busy = !hit1 && busy_q[rs1_sel];
    end
  end

  // Read port 2
  always_comb begin
    rs2_out  = '0;
    rs2_busy = 1'b0;
    if (run && (rs2_sel != '0)) begin
      rs2_out  = hit2 ? rd_data : regs_q[rs2_sel];
      rs2_busy = !hit2 && busy_q[rs2_sel];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb
//
// Instance a uses default parameters (XLEN=32, NREGS=32); instance b uses
// XLEN=64, NREGS=16. Inputs change 1 time unit after a rising edge; outputs
// are sampled on the falling edge (or 1 unit after a rising edge for the
// registered ready flag).
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a (defaults)
  logic        reset_n;
  logic        ready;
  logic [4:0]  rs1_sel, rs2_sel, rd_sel, iss_sel;
  logic [31:0] rs1_out, rs2_out, rd_data;
  logic        rs1_busy, rs2_busy;
  logic        rd_we, iss_valid, flush;

  // instance b (XLEN=64, NREGS=16)
  logic        b_reset_n;
  logic        b_ready;
  logic [3:0]  b_rs1_sel, b_rs2_sel, b_rd_sel, b_iss_sel;
  logic [63:0] b_rs1_out, b_rs2_out, b_rd_data;
  logic        b_rs1_busy, b_rs2_busy;
  logic        b_rd_we, b_iss_valid, b_flush;

  regfile_sb u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .ready     (ready),
    .rs1_sel   (rs1_sel),
    .rs1_out   (rs1_out),
    .rs1_busy  (rs1_busy),
    .rs2_sel   (rs2_sel),
    .rs2_out   (rs2_out),
    .rs2_busy  (rs2_busy),
    .rd_we     (rd_we),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .iss_valid (iss_valid),
    .iss_sel   (iss_sel),
    .flush     (flush)
  );

  regfile_sb #(.XLEN(64), .NREGS(16)) u_dut_b (
    .clk       (clk),
    .reset_n   (b_reset_n),
    .ready     (b_ready),
    .rs1_sel   (b_rs1_sel),
    .rs1_out   (b_rs1_out),
    .rs1_busy  (b_rs1_busy),
    .rs2_sel   (b_rs2_sel),
    .rs2_out   (b_rs2_out),
    .rs2_busy  (b_rs2_busy),
    .rd_we     (b_rd_we),
    .rd_sel    (b_rd_sel),
    .rd_data   (b_rd_data),
    .iss_valid (b_iss_valid),
    .iss_sel   (b_iss_sel),
    .flush     (b_flush)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] mdl [32];   // expected contents of instance a

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_out(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    rd_we = 1'b0; rd_sel = '0; rd_data = '0;
    iss_valid = 1'b0; iss_sel = '0; flush = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ready rises, bounded.
  task automatic count_sweep_a(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic count_sweep_b(output int n);
    n = 0;
    while (!b_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Writes a register in one cycle, no read checks.
  task automatic write_a(input logic [4:0] a, input logic [31:0] d);
    idle_a();
    rd_we = 1'b1; rd_sel = a; rd_data = d;
    if (a != 5'd0) mdl[a] = d;
    advance();
    idle_a();
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [4:0]  ra, rb;
    logic [31:0] rv;

    for (int i = 0; i < 32; i++) mdl[i] = '0;

    reset_n = 1'b0; rs1_sel = 5'd1; rs2_sel = 5'd2; idle_a();
    b_reset_n = 1'b0; b_rs1_sel = '0; b_rs2_sel = '0; b_rd_we = 1'b0;
    b_rd_sel = '0; b_rd_data = '0; b_iss_valid = 1'b0; b_iss_sel = '0;
    b_flush = 1'b0;

    // reset state
    #2;
    expect_val("reset_ready", 64'd0);  check_out(64'(ready));
    expect_val("reset_rs1_out", 64'd0); check_out(64'(rs1_out));
    expect_val("reset_rs1_busy", 64'd0); check_out(64'(rs1_busy));
    expect_val("reset_b_ready", 64'd0); check_out(64'(b_ready));

    // release and time the sweep
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_sweep_a(n);
    expect_val("sweep_len_a", 64'd32); check_out(64'(n));
    expect_val("ready_after_sweep", 64'd1); check_out(64'(ready));

    // every register reads 0 on both ports
    for (int i = 1; i < 32; i++) begin
      rs1_sel = 5'(i);
      rs2_sel = 5'(32 - i);
      expect_val($sformatf("init_rs1_x%0d", i), 64'd0);
      expect_val($sformatf("init_rs2_x%0d", 32 - i), 64'd0);
      @(negedge clk);
      check_out(64'(rs1_out));
      check_out(64'(rs2_out));
      advance();
    end

    // write x5 with same-cycle bypass, then from storage
    idle_a();
    rd_we = 1'b1; rd_sel = 5'd5; rd_data = 32'hDEADBEEF; mdl[5] = 32'hDEADBEEF;
    rs1_sel = 5'd5; rs2_sel = 5'd5;
    expect_val("bypass_x5_rs1", 64'hDEADBEEF);
    expect_val("bypass_x5_rs2", 64'hDEADBEEF);
    @(negedge clk);
    check_out(64'(rs1_out));
    check_out(64'(rs2_out));
    advance();
    idle_a();
    expect_val("stored_x5", 64'hDEADBEEF);
    @(negedge clk); check_out(64'(rs1_out)); advance();

    // write to x0 is dropped
    rd_we = 1'b1; rd_sel = 5'd0; rd_data = 32'hFFFFFFFF; rs2_sel = 5'd0;
    expect_val("x0_same_cycle", 64'd0);
    @(negedge clk); check_out(64'(rs2_out)); advance();
    idle_a();
    expect_val("x0_after", 64'd0);
    @(negedge clk); check_out(64'(rs2_out)); advance();

    // issue x7: not visible the same cycle, busy the next
    iss_valid = 1'b1; iss_sel = 5'd7; rs1_sel = 5'd7;
    expect_val("iss7_same_cycle_busy", 64'd0);
    @(negedge clk); check_out(64'(rs1_busy)); advance();
    idle_a();
    expect_val("iss7_busy", 64'd1);
    @(negedge clk); check_out(64'(rs1_busy)); advance();
    // writeback x7: busy drops and data bypasses in that cycle
    rd_we = 1'b1; rd_sel = 5'd7; rd_data = 32'h1234; mdl[7] = 32'h1234;
    expect_val("wb7_busy", 64'd0);
    expect_val("wb7_out", 64'h1234);
    @(negedge clk); check_out(64'(rs1_busy)); check_out(64'(rs1_out)); advance();
    idle_a();
    expect_val("wb7_busy_after", 64'd0);
    @(negedge clk); check_out(64'(rs1_busy)); advance();

    // issue and writeback x9 in one cycle: set wins
    iss_valid = 1'b1; iss_sel = 5'd9;
    rd_we = 1'b1; rd_sel = 5'd9; rd_data = 32'h99; mdl[9] = 32'h99;
    advance();
    idle_a();
    rs1_sel = 5'd9;
    expect_val("x9_set_wins_busy", 64'd1);
    expect_val("x9_data", 64'h99);
    @(negedge clk); check_out(64'(rs1_busy)); check_out(64'(rs1_out)); advance();

    // issue x3 with flush, plus a same-cycle data write to x10
    iss_valid = 1'b1; iss_sel = 5'd3; flush = 1'b1;
    rd_we = 1'b1; rd_sel = 5'd10; rd_data = 32'hA0A0; mdl[10] = 32'hA0A0;
    advance();
    idle_a();
    rs1_sel = 5'd9; rs2_sel = 5'd3;
    expect_val("flush_x9_busy", 64'd0);
    expect_val("flush_x3_busy", 64'd0);
    @(negedge clk); check_out(64'(rs1_busy)); check_out(64'(rs2_busy)); advance();
    rs1_sel = 5'd10;
    expect_val("flush_write_x10", 64'hA0A0);
    @(negedge clk); check_out(64'(rs1_out)); advance();

    // issue to x0 has no effect
    iss_valid = 1'b1; iss_sel = 5'd0;
    advance();
    idle_a();
    rs1_sel = 5'd0;
    expect_val("x0_never_busy", 64'd0);
    @(negedge clk); check_out(64'(rs1_busy)); advance();

    // random writes followed by dual-port reads against the model
    for (int k = 0; k < 8; k++) begin
      ra = 5'($urandom_range(1, 31));
      rv = $urandom;
      write_a(ra, rv);
      rb = 5'($urandom_range(0, 31));
      rs1_sel = ra; rs2_sel = rb;
      expect_val($sformatf("rand_rs1_x%0d", ra), 64'(mdl[ra]));
      expect_val($sformatf("rand_rs2_x%0d", rb), 64'(mdl[rb]));
      @(negedge clk); check_out(64'(rs1_out)); check_out(64'(rs2_out)); advance();
    end

    // reset mid-RUN with x4 busy
    write_a(5'd4, 32'h44);
    iss_valid = 1'b1; iss_sel = 5'd4;
    advance();
    idle_a();
    rs1_sel = 5'd4;
    expect_val("pre_reset_busy4", 64'd1);
    expect_val("pre_reset_out4", 64'h44);
    @(negedge clk); check_out(64'(rs1_busy)); check_out(64'(rs1_out));
    #2 reset_n = 1'b0;
    #1;
    expect_val("async_ready", 64'd0);
    expect_val("async_busy", 64'd0);
    expect_val("async_out", 64'd0);
    check_out(64'(ready)); check_out(64'(rs1_busy)); check_out(64'(rs1_out));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_sweep_a(n);
    expect_val("sweep_len_again", 64'd32); check_out(64'(n));
    expect_val("post_sweep_busy4", 64'd0);
    expect_val("post_sweep_out4", 64'd0);
    @(negedge clk); check_out(64'(rs1_busy)); check_out(64'(rs1_out)); advance();

    // instance b: 16-entry, 64-bit
    b_reset_n = 1'b1;
    count_sweep_b(n);
    expect_val("sweep_len_b", 64'd16); check_out(64'(n));
    b_rd_we = 1'b1; b_rd_sel = 4'd15; b_rd_data = 64'hFFFF_0000_AAAA_5555;
    b_rs1_sel = 4'd15;
    expect_val("b_bypass_x15", 64'hFFFF_0000_AAAA_5555);
    @(negedge clk); check_out(b_rs1_out); advance();
    b_rd_we = 1'b0; b_rs1_sel = 4'd1; b_rs2_sel = 4'd15;
    expect_val("b_stored_x15", 64'hFFFF_0000_AAAA_5555);
    expect_val("b_x1_zero", 64'd0);
    @(negedge clk); check_out(b_rs2_out); check_out(b_rs1_out); advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
